// File: rtl/vend_ctrl.sv
// Coin-credit vending controller: accumulates 0..8 units of credit, vends at PRICE,
// and pays any remaining credit back one unit per cycle. All outputs are registered.
module vend_ctrl #(
   parameter int unsigned PRICE = 6
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       coin_a,
   input  logic       coin_b,
   input  logic       select,
   input  logic       cancel,
   output logic [3:0] credit_code,
   output logic       vend,
   output logic       change,
   output logic       reject,
   output logic       deny,
   output logic       busy
);

   localparam logic [3:0] W_PRICE  = 4'(PRICE);
   localparam logic [3:0] W_MAXCRD = 4'd8;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      VEND   = 2'd1,
      RETURN = 2'd2
   } state_t;

   state_t     r_state;
   logic [3:0] r_credit;
   logic       r_vend;
   logic       r_change;
   logic       r_reject;
   logic       r_deny;
   logic       r_busy;

   logic [3:0] w_coin_val;
   logic       w_any_coin;
   logic       w_sel_ok;
   logic [3:0] w_sum;
   logic       w_coin_ok;
   logic [3:0] w_after_vend;

   // Coin pair value 0..3; the sum cannot wrap in 4 bits since credit <= 8.
   assign w_coin_val   = {2'b00, coin_b, coin_a};
   assign w_any_coin   = coin_a | coin_b;
   assign w_sel_ok     = select & ~cancel & (r_credit >= W_PRICE);
   assign w_sum        = r_credit + w_coin_val;
   assign w_coin_ok    = ~cancel & ~w_sel_ok & (w_sum <= W_MAXCRD);
   assign w_after_vend = r_credit - W_PRICE;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= IDLE;
         r_credit <= 4'd0;
         r_vend   <= 1'b0;
         r_change <= 1'b0;
         r_reject <= 1'b0;
         r_deny   <= 1'b0;
         r_busy   <= 1'b0;
      end else begin
         r_vend   <= 1'b0;
         r_change <= 1'b0;
         r_reject <= 1'b0;
         r_deny   <= 1'b0;
         r_busy   <= 1'b0;
         case (r_state)
            IDLE: begin
               if (cancel) begin
                  if (r_credit != 4'd0)
                     r_state <= RETURN;
               end else if (select) begin
                  if (w_sel_ok)
                     r_state <= VEND;
                  else
                     r_deny <= 1'b1;
               end
               // Coins are all-or-nothing; a refused pair goes back mechanically.
               if (w_any_coin) begin
                  if (w_coin_ok)
                     r_credit <= w_sum;
                  else
                     r_reject <= 1'b1;
               end
            end
            VEND: begin
               r_vend   <= 1'b1;
               r_busy   <= 1'b1;
               r_reject <= w_any_coin;
               r_credit <= w_after_vend;
               r_state  <= (w_after_vend != 4'd0) ? RETURN : IDLE;
            end
            RETURN: begin
               r_reject <= w_any_coin;
               if (r_credit != 4'd0) begin
                  r_change <= 1'b1;
                  r_busy   <= 1'b1;
                  r_credit <= r_credit - 4'd1;
                  if (r_credit == 4'd1)
                     r_state <= IDLE;
               end else begin
                  r_state <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign credit_code = r_credit;
   assign vend        = r_vend;
   assign change      = r_change;
   assign reject      = r_reject;
   assign deny        = r_deny;
   assign busy        = r_busy;

endmodule

// File: tb/tb_vend_ctrl.sv
// Directed bench for vend_ctrl at PRICE 6 plus boundary instances at PRICE 1 and 8.
// Outputs are compared as {credit_code, vend, change, reject, deny, busy}.
module tb_vend_ctrl;

   logic clk = 1'b0;
   logic rst6, rst1, rst8;
   logic coin_a, coin_b, select, cancel;
   logic [3:0] cc6, cc1, cc8;
   logic v6, ch6, rj6, dn6, b6;
   logic v1, ch1, rj1, dn1, b1;
   logic v8, ch8, rj8, dn8, b8;
   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   vend_ctrl #(.PRICE(6)) dut6 (
      .clk(clk), .reset(rst6), .coin_a(coin_a), .coin_b(coin_b), .select(select), .cancel(cancel),
      .credit_code(cc6), .vend(v6), .change(ch6), .reject(rj6), .deny(dn6), .busy(b6));
   vend_ctrl #(.PRICE(1)) dut1 (
      .clk(clk), .reset(rst1), .coin_a(coin_a), .coin_b(coin_b), .select(select), .cancel(cancel),
      .credit_code(cc1), .vend(v1), .change(ch1), .reject(rj1), .deny(dn1), .busy(b1));
   vend_ctrl #(.PRICE(8)) dut8 (
      .clk(clk), .reset(rst8), .coin_a(coin_a), .coin_b(coin_b), .select(select), .cancel(cancel),
      .credit_code(cc8), .vend(v8), .change(ch8), .reject(rj8), .deny(dn8), .busy(b8));

   wire [8:0] out6 = {cc6, v6, ch6, rj6, dn6, b6};
   wire [8:0] out1 = {cc1, v1, ch1, rj1, dn1, b1};
   wire [8:0] out8 = {cc8, v8, ch8, rj8, dn8, b8};

   function automatic logic [8:0] ev(input int c, input logic v, input logic ch,
                                     input logic rj, input logic dn, input logic bz);
      ev = {4'(c), v, ch, rj, dn, bz};
   endfunction

   task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   // Drive one cycle of inputs, let the edge sample them, then clear.
   task automatic cyc(input logic a, input logic b, input logic s, input logic c);
      coin_a = a; coin_b = b; select = s; cancel = c;
      @(posedge clk); #1;
      coin_a = 1'b0; coin_b = 1'b0; select = 1'b0; cancel = 1'b0;
   endtask

   task automatic s6(input string tag, input logic a, input logic b, input logic s, input logic c,
                     input logic [8:0] exp);
      cyc(a, b, s, c);
      chk(tag, out6, exp);
   endtask

   task automatic s18(input string tag, input logic a, input logic b, input logic s, input logic c,
                      input logic [8:0] e1, input logic [8:0] e8);
      cyc(a, b, s, c);
      chk({tag, "_p1"}, out1, e1);
      chk({tag, "_p8"}, out8, e8);
   endtask

   initial begin
      rst6 = 1'b1; rst1 = 1'b1; rst8 = 1'b1;
      coin_a = 1'b0; coin_b = 1'b0; select = 1'b0; cancel = 1'b0;
      @(posedge clk); @(posedge clk); #1;
      chk("reset6", out6, ev(0,0,0,0,0,0));
      chk("reset1", out1, ev(0,0,0,0,0,0));
      chk("reset8", out8, ev(0,0,0,0,0,0));
      rst6 = 1'b0;

      // Exact price: 3 x coin_b then select, no change
      s6("t1_b1",  0,1,0,0, ev(2,0,0,0,0,0));
      s6("t1_b2",  0,1,0,0, ev(4,0,0,0,0,0));
      s6("t1_b3",  0,1,0,0, ev(6,0,0,0,0,0));
      s6("t1_sel", 0,0,1,0, ev(6,0,0,0,0,0));
      s6("t1_vnd", 0,0,0,0, ev(0,1,0,0,0,1));
      s6("t1_end", 0,0,0,0, ev(0,0,0,0,0,0));

      // Credit 7, select: vend to 1 then one change; coin during VEND rejected
      s6("t2_b1",  0,1,0,0, ev(2,0,0,0,0,0));
      s6("t2_b2",  0,1,0,0, ev(4,0,0,0,0,0));
      s6("t2_b3",  0,1,0,0, ev(6,0,0,0,0,0));
      s6("t2_a",   1,0,0,0, ev(7,0,0,0,0,0));
      s6("t2_sel", 0,0,1,0, ev(7,0,0,0,0,0));
      s6("t2_vnd", 1,0,0,0, ev(1,1,0,1,0,1));
      s6("t2_chg", 0,0,0,0, ev(0,0,1,0,0,1));
      s6("t2_end", 0,0,0,0, ev(0,0,0,0,0,0));

      // Overflow rejects
      s6("t3_b1",  0,1,0,0, ev(2,0,0,0,0,0));
      s6("t3_b2",  0,1,0,0, ev(4,0,0,0,0,0));
      s6("t3_b3",  0,1,0,0, ev(6,0,0,0,0,0));
      s6("t3_a",   1,0,0,0, ev(7,0,0,0,0,0));
      s6("t3_rjb", 0,1,0,0, ev(7,0,0,1,0,0));
      s6("t3_a8",  1,0,0,0, ev(8,0,0,0,0,0));
      s6("t3_rjab",1,1,0,0, ev(8,0,0,1,0,0));
      // Spend 8: vend to 2, then two change pulses
      s6("t3_sel", 0,0,1,0, ev(8,0,0,0,0,0));
      s6("t3_vnd", 0,0,0,0, ev(2,1,0,0,0,1));
      s6("t3_ch1", 0,0,0,0, ev(1,0,1,0,0,1));
      s6("t3_ch2", 0,0,0,0, ev(0,0,1,0,0,1));
      s6("t3_end", 0,0,0,0, ev(0,0,0,0,0,0));

      // Deny, and deny with a same-cycle coin still accepted
      s6("t4_a",   1,0,0,0, ev(1,0,0,0,0,0));
      s6("t4_b",   0,1,0,0, ev(3,0,0,0,0,0));
      s6("t4_dny", 0,0,1,0, ev(3,0,0,0,1,0));
      s6("t4_dna", 1,0,1,0, ev(4,0,0,0,1,0));

      // Cancel with credit 5; coin during RETURN rejected; back-to-back coin
      s6("t5_a",   1,0,0,0, ev(5,0,0,0,0,0));
      s6("t5_can", 0,0,0,1, ev(5,0,0,0,0,0));
      s6("t5_c4",  0,0,0,0, ev(4,0,1,0,0,1));
      s6("t5_c3",  1,0,0,0, ev(3,0,1,1,0,1));
      s6("t5_c2",  0,0,0,0, ev(2,0,1,0,0,1));
      s6("t5_c1",  0,0,0,0, ev(1,0,1,0,0,1));
      s6("t5_c0",  0,0,0,0, ev(0,0,1,0,0,1));
      s6("t5_b2b", 0,1,0,0, ev(2,0,0,0,0,0));
      s6("t5_can2",0,0,0,1, ev(2,0,0,0,0,0));
      s6("t5_d1",  0,0,0,0, ev(1,0,1,0,0,1));
      s6("t5_d0",  0,0,0,0, ev(0,0,1,0,0,1));
      s6("t5_can0",0,0,0,1, ev(0,0,0,0,0,0));
      s6("t5_cnab",1,0,0,1, ev(0,0,0,1,0,0));
      s6("t5_dny0",0,0,1,0, ev(0,0,0,0,1,0));

      // Reset in the first RETURN cycle abandons the refund
      s6("t6_b1",  0,1,0,0, ev(2,0,0,0,0,0));
      s6("t6_b2",  0,1,0,0, ev(4,0,0,0,0,0));
      s6("t6_b3",  0,1,0,0, ev(6,0,0,0,0,0));
      s6("t6_b4",  0,1,0,0, ev(8,0,0,0,0,0));
      s6("t6_sel", 0,0,1,0, ev(8,0,0,0,0,0));
      s6("t6_vnd", 0,0,0,0, ev(2,1,0,0,0,1));
      rst6 = 1'b1;
      s6("t6_rst", 0,0,0,0, ev(0,0,0,0,0,0));
      rst6 = 1'b0;
      s6("t6_q1",  0,0,0,0, ev(0,0,0,0,0,0));
      s6("t6_q2",  0,0,0,0, ev(0,0,0,0,0,0));

      // PRICE boundaries: 1 and 8 driven with the same stimulus
      rst6 = 1'b1; rst1 = 1'b0; rst8 = 1'b0;
      s18("pb_a",   1,0,0,0, ev(1,0,0,0,0,0), ev(1,0,0,0,0,0));
      s18("pb_sel", 0,0,1,0, ev(1,0,0,0,0,0), ev(1,0,0,0,1,0));
      s18("pb_v1",  0,0,0,0, ev(0,1,0,0,0,1), ev(1,0,0,0,0,0));
      s18("pb_i1",  0,0,0,0, ev(0,0,0,0,0,0), ev(1,0,0,0,0,0));
      s18("pb_b1",  0,1,0,0, ev(2,0,0,0,0,0), ev(3,0,0,0,0,0));
      s18("pb_b2",  0,1,0,0, ev(4,0,0,0,0,0), ev(5,0,0,0,0,0));
      s18("pb_b3",  0,1,0,0, ev(6,0,0,0,0,0), ev(7,0,0,0,0,0));
      s18("pb_a2",  1,0,0,0, ev(7,0,0,0,0,0), ev(8,0,0,0,0,0));
      s18("pb_sl2", 0,0,1,0, ev(7,0,0,0,0,0), ev(8,0,0,0,0,0));
      s18("pb_v2",  0,0,0,0, ev(6,1,0,0,0,1), ev(0,1,0,0,0,1));
      s18("pb_c5",  0,0,0,0, ev(5,0,1,0,0,1), ev(0,0,0,0,0,0));
      s18("pb_c4",  0,0,0,0, ev(4,0,1,0,0,1), ev(0,0,0,0,0,0));
      s18("pb_c3",  0,0,0,0, ev(3,0,1,0,0,1), ev(0,0,0,0,0,0));
      s18("pb_c2",  0,0,0,0, ev(2,0,1,0,0,1), ev(0,0,0,0,0,0));
      s18("pb_c1",  0,0,0,0, ev(1,0,1,0,0,1), ev(0,0,0,0,0,0));
      s18("pb_c0",  0,0,0,0, ev(0,0,1,0,0,1), ev(0,0,0,0,0,0));
      s18("pb_end", 0,0,0,0, ev(0,0,0,0,0,0), ev(0,0,0,0,0,0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/vend_ctrl.md
# vend_ctrl

Credit-accumulation and dispense controller for the vending machine. It counts inserted coins as a credit of 0–8 units and vends when the user selects with enough credit. Any remaining change is returned one unit per cycle. The registered 4-bit credit code drives the 4-to-9 one-hot credit decoder, which lights the credit LEDs; the controller never presents a code above 8.

## Interface
Parameters:
- PRICE, 6, item price in credit units; legal range 1..8.

Ports:
- clk  input  1  single system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- coin_a  input  1  one-cycle pulse: 1-unit coin inserted.
- coin_b  input  1  one-cycle pulse: 2-unit coin inserted.
- select  input  1  one-cycle pulse: purchase request.
- cancel  input  1  one-cycle pulse: abort and refund all credit.
- credit_code  output  4  current credit, 0..8; feeds decoder inputs X0..X3 (bit 0 = X0).
- vend  output  1  one-cycle pulse: dispense item.
- change  output  1  one-cycle pulse per returned unit.
- reject  output  1  one-cycle pulse: coin(s) this cycle refused, returned mechanically.
- deny  output  1  one-cycle pulse: select refused for insufficient credit.
- busy  output  1  high in VEND and RETURN states.

## Operation
- State machine states: IDLE, VEND, RETURN. All outputs are registered.
- Reset values: state IDLE, credit_code 0, vend 0, change 0, reject 0, deny 0, busy 0.
- IDLE events are evaluated in priority order: cancel, then select, then coins.
  - cancel: if credit > 0, go to RETURN; if credit = 0, stay in IDLE with no pulse.
  - select with credit ≥ PRICE: go to VEND.
  - select with credit < PRICE: deny = 1 for one cycle; coins in the same cycle are still processed.
  - coins: value = coin_a + 2·coin_b, so 0..3 units.
- Coin acceptance in IDLE:
  - Accepted only when no cancel and no accepted select occur in the same cycle, and credit + value ≤ 8.
  - Accepted: credit += value.
  - Otherwise: the whole value is refused, reject = 1, credit unchanged.
  - Coin pairs are never partially accepted.
- VEND (one cycle):
  - vend = 1 and credit −= PRICE.
  - Next state is RETURN if the new credit > 0, else IDLE.
- RETURN:
  - change = 1 and credit −= 1 each cycle until credit reaches 0, then IDLE.
  - The cycle that outputs the last change pulse shows credit_code = 0.
- In VEND and RETURN, select and cancel are ignored. Any coin pulse produces reject = 1.
- Arithmetic is 4-bit unsigned. credit never exceeds 8 and never underflows, because PRICE ≤ credit is checked before VEND.
- Reset asserted mid-operation (VEND or RETURN) returns to IDLE with credit 0 on the next edge. No further vend or change pulses are issued, and the pending refund is abandoned.

## Timing
- Latency for all inputs is 1 cycle: inputs sampled at edge N, effect visible after edge N.
- A coin sampled at edge N updates credit_code from edge N onward; reject and deny follow the same timing.
- select accepted at edge N:
  - vend high for the cycle after edge N+1, with credit_code = credit − PRICE.
  - If change is owed, change pulses occupy the following r cycles, where r = remainder.
  - busy is high for the 1 + r cycles of VEND + RETURN.
- cancel with credit c: c change pulses on consecutive cycles starting one cycle after the sampling edge. busy is high for exactly those c cycles.
- Back-to-back: a new select or coin is accepted in the first cycle after busy falls.
- Inputs are assumed to be synchronous, single-cycle pulses. A pulse held high for k cycles counts as k events.

## Test plan
- Reset, then coin_b ×3 (credit 6), then select (PRICE = 6): credit_code 2→4→6, vend for 1 cycle, credit_code 0, no change pulses, busy for 1 cycle.
- Credit 7 by coin_b ×3 + coin_a, then select: vend with credit_code 1, then 1 change pulse to credit 0, busy for 2 cycles.
- Credit 7, then coin_b: reject = 1 and credit stays 7. Then coin_a: credit 8. Then coin_a and coin_b together: reject = 1 and credit stays 8.
- Credit 3, then select: deny = 1 and credit stays 3. Then select + coin_a in the same cycle with credit 3: deny = 1 and credit becomes 4.
- Credit 5, then cancel: 5 consecutive change pulses, credit_code 4,3,2,1,0, busy for 5 cycles. A coin_a during RETURN gives reject = 1 and does not change the count.
- Credit 8, select, then reset asserted in the first RETURN cycle: the next cycle shows credit_code 0 and busy 0, and no further change pulses occur. Also sweep PRICE = 1 and 8 for the boundary vend cases.
